// File: rtl/vga_layer_scheduler_pkg.sv
// Shared encodings for the VGA layer scheduler: layer select codes, overlay FSM
// states and the mode codes mirrored from the VGA parameter header.
package vga_layer_scheduler_pkg;

  typedef enum logic [3:0] {
    LAYER_BLANK   = 4'd0,
    LAYER_BASE    = 4'd1,
    LAYER_NOTES   = 4'd2,
    LAYER_PROCESS = 4'd3,
    LAYER_REC     = 4'd4,
    LAYER_SAVEDEL = 4'd5
  } layer_e;

  typedef enum logic [1:0] {
    OVL_IDLE    = 2'd0,
    OVL_REC     = 2'd1,
    OVL_CONFIRM = 2'd2,
    OVL_HOLD    = 2'd3
  } ovl_state_e;

  // Same values as the VGA parameter header so mode_req passes through untouched.
  localparam logic [7:0] MODE_WELCOME  = 8'd0;
  localparam logic [7:0] MODE_MENU     = 8'd1;
  localparam logic [7:0] MODE_PLAY     = 8'd2;
  localparam logic [7:0] MODE_LEARN    = 8'd3;
  localparam logic [7:0] MODE_GAME     = 8'd4;
  localparam logic [7:0] MODE_SETTINGS = 8'd5;

  localparam logic [9:0] FRAME_CNT_MAX = 10'd1023;

  // Block modes draw falling blocks, the progress bar and the notes keyboard;
  // every other code is a full-screen page.
  function automatic logic is_block_mode(input logic [7:0] mode);
    return (mode == MODE_PLAY) || (mode == MODE_LEARN) || (mode == MODE_GAME);
  endfunction

endpackage

// File: rtl/vga_layer_scheduler_tick.sv
// Frame-start pulse generator and saturating per-state frame counter.
module vga_frame_tick
  import vga_layer_scheduler_pkg::*;
(
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       clr,
  output logic       frame_start,
  output logic [9:0] cnt
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      cnt         <= '0;
    end else begin
      frame_start <= (pos_x == 10'd0) && (pos_y == 10'd0);
      if (clr)
        cnt <= '0;
      else if (frame_start && (cnt != FRAME_CNT_MAX))
        cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_layer_scheduler.sv
// Frame-synchronous mode commit, REC/popup overlay sequencing and registered
// layer select. Optional VGA_SCHED_BLANK_SWITCH_EN blanks the frame after a mode change.
module vga_layer_scheduler
  import vga_layer_scheduler_pkg::*;
#(
  parameter logic [7:0] BLINK_FRAMES = 8'd30,
  parameter logic [9:0] POPUP_FRAMES = 10'd600,
  parameter logic [7:0] HOLD_FRAMES  = 8'd15,
  parameter logic [9:0] TOP_BAR_Y    = 10'd5,
  parameter logic [9:0] PLAY_Y_MAX   = 10'd384,
  parameter logic [9:0] NOTES_Y_MIN  = 10'd416
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [7:0] mode_req,
  input  logic       recording,
  input  logic       handling_rec,
  output logic [7:0] mode_frame,
  output logic       frame_start,
  output logic [3:0] layer_sel,
  output logic       rec_visible,
  output logic       popup_visible,
  output logic       popup_timeout
);

  ovl_state_e ovl_q, ovl_d;
  logic [9:0] frame_cnt;
  logic       cnt_clr;
  logic       timeout_d;
  logic       blink_odd;
  logic       block_mode;
  layer_e     layer_d;

  vga_frame_tick u_tick (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .clr         (cnt_clr),
    .frame_start (frame_start),
    .cnt         (frame_cnt)
  );

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ovl_d     = ovl_q;
    timeout_d = 1'b0;
    if (frame_start) begin
      case (ovl_q)
        OVL_IDLE:
          if (recording) ovl_d = OVL_REC;
        OVL_REC:
          if (!recording) ovl_d = handling_rec ? OVL_CONFIRM : OVL_IDLE;
        OVL_CONFIRM:
          if (!handling_rec) begin
            ovl_d = OVL_HOLD;
          end else if (frame_cnt == POPUP_FRAMES - 10'd1) begin
            ovl_d     = OVL_HOLD;
            timeout_d = 1'b1;
          end
        OVL_HOLD:
          if (frame_cnt >= {2'b00, HOLD_FRAMES}) ovl_d = OVL_IDLE;
        default: ovl_d = OVL_IDLE;
      endcase
    end
  end

  // The counter restarts on every state change so each state times from zero.
  assign cnt_clr       = (ovl_d != ovl_q);
  assign blink_odd     = ((frame_cnt / {2'b00, BLINK_FRAMES}) & 10'd1) != 10'd0;
  assign rec_visible   = (ovl_q == OVL_REC) && !blink_odd;
  assign popup_visible = (ovl_q == OVL_CONFIRM);
  assign block_mode    = is_block_mode(mode_frame);

`ifdef VGA_SCHED_BLANK_SWITCH_EN
  logic blank_frame;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n)
      blank_frame <= 1'b0;
    else if (frame_start)
      blank_frame <= (mode_req != mode_frame);
  end
`endif

  always_comb begin
    layer_d = LAYER_BLANK;
    if (block_mode && (pos_y <= TOP_BAR_Y))
      layer_d = LAYER_PROCESS;
    else if (rec_visible)
      layer_d = LAYER_REC;
    else if (popup_visible)
      layer_d = LAYER_SAVEDEL;
    else if (!block_mode || (pos_y <= PLAY_Y_MAX))
      layer_d = LAYER_BASE;
    else if (pos_y >= NOTES_Y_MIN)
      layer_d = LAYER_NOTES;
`ifdef VGA_SCHED_BLANK_SWITCH_EN
    if (blank_frame)
      layer_d = LAYER_BLANK;
`endif
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_q         <= OVL_IDLE;
      popup_timeout <= 1'b0;
      mode_frame    <= MODE_WELCOME;
      layer_sel     <= LAYER_BLANK;
    end else begin
      ovl_q         <= ovl_d;
      popup_timeout <= timeout_d;
      layer_sel     <= layer_d;
      if (frame_start)
        mode_frame <= mode_req;
    end
  end

endmodule

// File: tb/tb_vga_layer_scheduler.sv
// Directed self-checking bench for vga_layer_scheduler with short frame-count
// parameters; frames are emulated by presenting (0,0) once per frame.
module tb_vga_layer_scheduler;
  import vga_layer_scheduler_pkg::*;

  logic       vga_clk = 1'b0;
  logic       rst_n;
  logic [9:0] pos_x, pos_y;
  logic [7:0] mode_req;
  logic       recording, handling_rec;
  logic [7:0] mode_frame;
  logic       frame_start;
  logic [3:0] layer_sel;
  logic       rec_visible, popup_visible, popup_timeout;

  int n_vec = 0;
  int n_err = 0;

  vga_layer_scheduler #(
    .BLINK_FRAMES (8'd2),
    .POPUP_FRAMES (10'd4),
    .HOLD_FRAMES  (8'd2)
  ) dut (
    .vga_clk       (vga_clk),
    .rst_n         (rst_n),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .mode_req      (mode_req),
    .recording     (recording),
    .handling_rec  (handling_rec),
    .mode_frame    (mode_frame),
    .frame_start   (frame_start),
    .layer_sel     (layer_sel),
    .rec_visible   (rec_visible),
    .popup_visible (popup_visible),
    .popup_timeout (popup_timeout)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_layer(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed layer %0d expected layer %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_mode(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed mode %0d expected mode %0d", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge: one cycle at (0,0), then one cycle
  // mid-screen during which every frame_start update lands.
  task automatic frame();
    pos_x = 10'd0;
    pos_y = 10'd0;
    @(negedge vga_clk);
    chk1("frame_start_pulse", frame_start, 1'b1);
    pos_x = 10'd320;
    pos_y = 10'd240;
    @(negedge vga_clk);
    chk1("frame_start_clear", frame_start, 1'b0);
  endtask

  task automatic probe(input logic [9:0] y, input logic [3:0] exp, input string tag);
    pos_x = 10'd100;
    pos_y = y;
    @(negedge vga_clk);
    chk_layer(tag, layer_sel, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] blink_exp;
    blink_exp    = 5'b10011;  // frame 0 is bit 0: 1,1,0,0,1
    rst_n        = 1'b0;
    pos_x        = 10'd100;
    pos_y        = 10'd100;
    mode_req     = MODE_WELCOME;
    recording    = 1'b0;
    handling_rec = 1'b0;
    repeat (3) @(negedge vga_clk);

    // Reset state
    chk_mode("rst_mode", mode_frame, MODE_WELCOME);
    chk_layer("rst_layer", layer_sel, LAYER_BLANK);
    chk1("rst_frame_start", frame_start, 1'b0);
    chk1("rst_rec", rec_visible, 1'b0);
    chk1("rst_popup", popup_visible, 1'b0);
    chk1("rst_timeout", popup_timeout, 1'b0);

    // 1: mid-frame mode request waits for frame start
    rst_n    = 1'b1;
    mode_req = MODE_PLAY;
    pos_x    = 10'd300;
    pos_y    = 10'd200;
    repeat (2) @(negedge vga_clk);
    chk_mode("mode_hold_midframe", mode_frame, MODE_WELCOME);
    chk_layer("welcome_base", layer_sel, LAYER_BASE);
    frame();
    chk_mode("mode_commit_play", mode_frame, MODE_PLAY);
    frame();

    // 2: play-mode region map, including boundaries
    probe(10'd3,   LAYER_PROCESS, "play_y3");
    probe(10'd5,   LAYER_PROCESS, "play_y5");
    probe(10'd6,   LAYER_BASE,    "play_y6");
    probe(10'd200, LAYER_BASE,    "play_y200");
    probe(10'd384, LAYER_BASE,    "play_y384");
    probe(10'd385, LAYER_BLANK,   "play_y385");
    probe(10'd400, LAYER_BLANK,   "play_y400");
    probe(10'd416, LAYER_NOTES,   "play_y416");
    probe(10'd450, LAYER_NOTES,   "play_y450");
    pos_y = 10'd3;
    chk_layer("latency_old_value", layer_sel, LAYER_NOTES);
    @(negedge vga_clk);
    chk_layer("latency_new_value", layer_sel, LAYER_PROCESS);

    // 3: REC blink pattern with BLINK_FRAMES=2
    recording = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame();
      chk1($sformatf("rec_blink_f%0d", i), rec_visible, blink_exp[i]);
      chk1($sformatf("rec_no_popup_f%0d", i), popup_visible, 1'b0);
      if (i == 0) begin
        probe(10'd5,   LAYER_PROCESS, "rec_y5");
        probe(10'd6,   LAYER_REC,     "rec_y6");
        probe(10'd479, LAYER_REC,     "rec_y479");
      end
      if (i == 2) probe(10'd200, LAYER_BASE, "rec_hidden_y200");
    end

    // 4: popup for POPUP_FRAMES=4 frames, timeout pulse, then HOLD
    recording    = 1'b0;
    handling_rec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame();
      chk1($sformatf("popup_on_f%0d", i), popup_visible, 1'b1);
      chk1($sformatf("popup_no_timeout_f%0d", i), popup_timeout, 1'b0);
      chk1($sformatf("popup_no_rec_f%0d", i), rec_visible, 1'b0);
      if (i == 0) begin
        probe(10'd200, LAYER_SAVEDEL, "popup_y200");
        probe(10'd3,   LAYER_PROCESS, "popup_y3");
      end
    end
    frame();
    chk1("popup_closed", popup_visible, 1'b0);
    chk1("timeout_pulse", popup_timeout, 1'b1);
    recording    = 1'b1;
    handling_rec = 1'b0;
    @(negedge vga_clk);
    chk1("timeout_one_cycle", popup_timeout, 1'b0);
    for (int i = 0; i < 3; i++) begin
      frame();
      chk1($sformatf("hold_ignores_rec_f%0d", i), rec_visible, 1'b0);
      chk1($sformatf("hold_no_timeout_f%0d", i), popup_timeout, 1'b0);
    end
    frame();
    chk1("rec_after_hold", rec_visible, 1'b1);

    // 5: simultaneous inputs, async reset mid-CONFIRM
    recording = 1'b0;
    frame();
    chk1("rec_to_idle", rec_visible, 1'b0);
    chk1("rec_to_idle_popup", popup_visible, 1'b0);
    recording    = 1'b1;
    handling_rec = 1'b1;
    frame();
    chk1("both_high_rec", rec_visible, 1'b1);
    chk1("both_high_no_popup", popup_visible, 1'b0);
    recording = 1'b0;
    frame();
    chk1("confirm_before_reset", popup_visible, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_popup", popup_visible, 1'b0);
    chk1("async_rst_rec", rec_visible, 1'b0);
    chk_mode("async_rst_mode", mode_frame, MODE_WELCOME);
    chk_layer("async_rst_layer", layer_sel, LAYER_BLANK);
    @(negedge vga_clk);
    rst_n = 1'b1;
    frame();
    chk_mode("post_rst_commit", mode_frame, MODE_PLAY);
    chk1("post_rst_idle_popup", popup_visible, 1'b0);
    chk1("post_rst_idle_rec", rec_visible, 1'b0);

    // User decision closes the popup without a timeout pulse
    recording = 1'b1;
    frame();
    recording = 1'b0;
    frame();
    chk1("decide_popup_open", popup_visible, 1'b1);
    handling_rec = 1'b0;
    frame();
    chk1("decide_popup_closed", popup_visible, 1'b0);
    chk1("decide_no_timeout", popup_timeout, 1'b0);
    repeat (3) frame();

    // Last mode request within a frame wins
    mode_req = MODE_LEARN;
    @(negedge vga_clk);
    mode_req = MODE_GAME;
    @(negedge vga_clk);
    mode_req = MODE_MENU;
    frame();
    chk_mode("last_req_wins", mode_frame, MODE_MENU);
    frame();
    probe(10'd3,   LAYER_BASE, "menu_y3");
    probe(10'd450, LAYER_BASE, "menu_y450");

    // 6: frame following a mode change
    mode_req = MODE_PLAY;
    frame();
`ifdef VGA_SCHED_BLANK_SWITCH_EN
    probe(10'd200, LAYER_BLANK, "switch_y200");
    probe(10'd3,   LAYER_BLANK, "switch_y3");
    probe(10'd450, LAYER_BLANK, "switch_y450");
`else
    probe(10'd200, LAYER_BASE,    "switch_y200");
    probe(10'd3,   LAYER_PROCESS, "switch_y3");
    probe(10'd450, LAYER_NOTES,   "switch_y450");
`endif
    frame();
    probe(10'd200, LAYER_BASE,    "steady_y200");
    probe(10'd3,   LAYER_PROCESS, "steady_y3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
